// File: rtl/cv_ctrl_pkg.sv
// Shared constants and helpers for the ColecoVision controller front end:
// keypad codes, joystick-word bit positions and the quadrature phase type.
package cv_ctrl_pkg;

  localparam logic [3:0] cv_key_0_c     = 4'b0011;
  localparam logic [3:0] cv_key_1_c     = 4'b1110;
  localparam logic [3:0] cv_key_2_c     = 4'b1101;
  localparam logic [3:0] cv_key_3_c     = 4'b0110;
  localparam logic [3:0] cv_key_4_c     = 4'b0001;
  localparam logic [3:0] cv_key_5_c     = 4'b1001;
  localparam logic [3:0] cv_key_6_c     = 4'b0111;
  localparam logic [3:0] cv_key_7_c     = 4'b1100;
  localparam logic [3:0] cv_key_8_c     = 4'b1000;
  localparam logic [3:0] cv_key_9_c     = 4'b1011;
  localparam logic [3:0] cv_key_star_c  = 4'b1010;
  localparam logic [3:0] cv_key_hash_c  = 4'b0101;
  localparam logic [3:0] cv_key_pt_c    = 4'b0100;
  localparam logic [3:0] cv_key_bt_c    = 4'b0010;
  localparam logic [3:0] cv_key_none_c  = 4'b1111;

  localparam int unsigned JOY_RIGHT_C = 0;
  localparam int unsigned JOY_LEFT_C  = 1;
  localparam int unsigned JOY_DOWN_C  = 2;
  localparam int unsigned JOY_UP_C    = 3;
  localparam int unsigned JOY_BTN1_C  = 4;
  localparam int unsigned JOY_BTN2_C  = 5;
  localparam int unsigned JOY_STAR_C  = 6;
  localparam int unsigned JOY_HASH_C  = 7;
  localparam int unsigned JOY_DIG0_C  = 8;
  localparam int unsigned JOY_PT_C    = 18;
  localparam int unsigned JOY_BT_C    = 19;

  typedef enum logic [1:0] {
    QPH_11 = 2'b11,
    QPH_01 = 2'b01,
    QPH_00 = 2'b00,
    QPH_10 = 2'b10
  } quad_phase_t;

  function automatic quad_phase_t quad_next(input quad_phase_t ph);
    case (ph)
      QPH_11:  return QPH_01;
      QPH_01:  return QPH_00;
      QPH_00:  return QPH_10;
      default: return QPH_11;
    endcase
  endfunction

  function automatic quad_phase_t quad_prev(input quad_phase_t ph);
    case (ph)
      QPH_11:  return QPH_10;
      QPH_10:  return QPH_00;
      QPH_00:  return QPH_01;
      default: return QPH_11;
    endcase
  endfunction

  // Keypad priority encoder over joystick bits [19:6]; first match wins.
  function automatic logic [3:0] kp_encode(input logic [19:6] keys);
    logic [3:0] code;
    code = cv_key_none_c;
    if      (keys[JOY_DIG0_C + 0]) code = cv_key_0_c;
    else if (keys[JOY_DIG0_C + 1]) code = cv_key_1_c;
    else if (keys[JOY_DIG0_C + 2]) code = cv_key_2_c;
    else if (keys[JOY_DIG0_C + 3]) code = cv_key_3_c;
    else if (keys[JOY_DIG0_C + 4]) code = cv_key_4_c;
    else if (keys[JOY_DIG0_C + 5]) code = cv_key_5_c;
    else if (keys[JOY_DIG0_C + 6]) code = cv_key_6_c;
    else if (keys[JOY_DIG0_C + 7]) code = cv_key_7_c;
    else if (keys[JOY_DIG0_C + 8]) code = cv_key_8_c;
    else if (keys[JOY_DIG0_C + 9]) code = cv_key_9_c;
    else if (keys[JOY_STAR_C])     code = cv_key_star_c;
    else if (keys[JOY_HASH_C])     code = cv_key_hash_c;
    else if (keys[JOY_PT_C])       code = cv_key_pt_c;
    else if (keys[JOY_BT_C])       code = cv_key_bt_c;
    return code;
  endfunction

endpackage

// File: rtl/cv_quad_gen.sv
// Per-player roller/spinner quadrature generator: spinner toggle detect,
// saturating step accumulator, step timer and A/B phase register.
module cv_quad_gen
  import cv_ctrl_pkg::*;
#(
  parameter logic [11:0] STEP_CE = 12'd256,
  parameter int          ACC_W   = 10
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       ce_i,
  input  logic [8:0] spinner_i,
  output logic       quad_a_o,
  output logic       quad_b_o
);

  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX_C = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN_C = -ACC_MAX_C;

  logic                    r_tog;
  logic signed [ACC_W-1:0] r_acc;
  logic [11:0]             r_timer;
  quad_phase_t             r_phase;

  logic                    w_evt;
  logic                    w_wrap;
  logic                    w_step;
  logic                    w_neg;
  logic signed [SUM_W-1:0] w_delta;
  logic signed [SUM_W-1:0] w_adj;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_sat;

  assign w_evt   = spinner_i[8] ^ r_tog;
  assign w_wrap  = ce_i && (r_timer == STEP_CE - 12'd1);
  assign w_step  = w_wrap && (r_acc != '0);
  assign w_neg   = r_acc[ACC_W-1];
  assign w_delta = w_evt ? {{(SUM_W-8){spinner_i[7]}}, spinner_i[7:0]} : '0;
  // A step consumes one unit of the accumulator, moving it toward zero.
  assign w_adj   = !w_step ? '0 : (w_neg ? SUM_W'(1) : '1);
  assign w_sum   = {{2{r_acc[ACC_W-1]}}, r_acc} + w_delta + w_adj;

  always_comb begin
    w_sat = w_sum;
    if (w_sum > ACC_MAX_C)      w_sat = ACC_MAX_C;
    else if (w_sum < ACC_MIN_C) w_sat = ACC_MIN_C;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      // Track the toggle during reset so release does not fake an event.
      r_tog   <= spinner_i[8];
      r_acc   <= '0;
      r_timer <= '0;
      r_phase <= QPH_11;
    end else begin
      r_tog <= spinner_i[8];
      r_acc <= w_sat[ACC_W-1:0];
      if (ce_i) r_timer <= w_wrap ? 12'd0 : r_timer + 12'd1;
      if (w_step) r_phase <= w_neg ? quad_prev(r_phase) : quad_next(r_phase);
    end
  end

  assign quad_a_o = r_phase[1];
  assign quad_b_o = r_phase[0];

endmodule

// File: rtl/cv_ctrl_mux.sv
// N-player ColecoVision controller front end: keypad encode, hold stretch and
// p5/p8 port muxing. Define CV_ROLLER_EN to add the quadrature generators.
module cv_ctrl_mux
  import cv_ctrl_pkg::*;
#(
  parameter int          NUM_PLAYERS = 2,
  parameter logic [15:0] HOLD_CE     = 16'd4096,
  parameter logic [11:0] STEP_CE     = 12'd256,
  parameter int          ACC_W       = 10
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     ce_i,
  input  logic [NUM_PLAYERS*32-1:0] joy_i,
  input  logic [NUM_PLAYERS*9-1:0]  spinner_i,
  input  logic [NUM_PLAYERS-1:0]    ctrl_p5_i,
  input  logic [NUM_PLAYERS-1:0]    ctrl_p8_i,
  output logic [NUM_PLAYERS*4-1:0]  ctrl_p1_4_o,
  output logic [NUM_PLAYERS-1:0]    ctrl_p6_o,
  output logic [NUM_PLAYERS-1:0]    ctrl_p7_o,
  output logic [NUM_PLAYERS-1:0]    ctrl_p9_o
);

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic [31:0] w_joy;
    logic [3:0]  w_raw_code;
    logic [3:0]  w_kp;
    logic [3:0]  w_js;
    logic        w_fire;
    logic        w_unused_hi;
    logic [3:0]  r_held_code;
    logic [15:0] r_hold_cnt;
    logic [3:0]  r_port;
    logic        r_fire;

    assign w_joy       = joy_i[32*gi +: 32];
    assign w_unused_hi = ^w_joy[31:20];
    assign w_raw_code  = kp_encode(w_joy[19:6]);

    // New codes are only latched once the previous one has been held long
    // enough for the BIOS keypad scan to see it.
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        r_held_code <= cv_key_none_c;
        r_hold_cnt  <= '0;
      end else if (r_hold_cnt == '0) begin
        if (w_raw_code == cv_key_none_c) begin
          r_held_code <= cv_key_none_c;
        end else if (w_raw_code != r_held_code) begin
          r_held_code <= w_raw_code;
          r_hold_cnt  <= HOLD_CE;
        end
      end else if (ce_i) begin
        r_hold_cnt <= r_hold_cnt - 16'd1;
      end
    end

    assign w_kp   = ctrl_p5_i[gi] ? cv_key_none_c : r_held_code;
    assign w_js   = ctrl_p8_i[gi] ? cv_key_none_c :
                    ~{w_joy[JOY_UP_C], w_joy[JOY_DOWN_C], w_joy[JOY_LEFT_C], w_joy[JOY_RIGHT_C]};
    assign w_fire = (ctrl_p5_i[gi] ? 1'b1 : ~w_joy[JOY_BTN2_C]) &
                    (ctrl_p8_i[gi] ? 1'b1 : ~w_joy[JOY_BTN1_C]);

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        r_port <= cv_key_none_c;
        r_fire <= 1'b1;
      end else begin
        r_port <= w_kp & w_js;
        r_fire <= w_fire;
      end
    end

    assign ctrl_p1_4_o[4*gi +: 4] = r_port;
    assign ctrl_p6_o[gi]          = r_fire;

`ifdef CV_ROLLER_EN
    cv_quad_gen #(
      .STEP_CE (STEP_CE),
      .ACC_W   (ACC_W)
    ) u_quad (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .ce_i      (ce_i),
      .spinner_i (spinner_i[9*gi +: 9]),
      .quad_a_o  (ctrl_p7_o[gi]),
      .quad_b_o  (ctrl_p9_o[gi])
    );
`else
    assign ctrl_p7_o[gi] = 1'b1;
    assign ctrl_p9_o[gi] = 1'b1;
`endif
  end

`ifndef CV_ROLLER_EN
  localparam int unused_quad_cfg_c = int'(STEP_CE) + ACC_W;
  logic w_unused_spinner;
  assign w_unused_spinner = ^spinner_i;
`endif

endmodule

// File: tb/tb_cv_ctrl_mux.sv
// Directed bench for cv_ctrl_mux: reset, keypad priority/hold, port muxing,
// and (with CV_ROLLER_EN) quadrature stepping and accumulator saturation.
module tb_cv_ctrl_mux;

  localparam int          NP    = 2;
  localparam logic [15:0] HOLD  = 16'd20;
  localparam logic [11:0] STEP  = 12'd8;
  localparam int          ACC_W = 10;
  localparam int          H     = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b1;
  logic [NP*32-1:0] joy = '0;
  logic [NP*9-1:0]  spin = '0;
  logic [NP-1:0] p5 = '1;
  logic [NP-1:0] p8 = '1;
  logic [NP*4-1:0] p14;
  logic [NP-1:0] p6, p7, p9;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] kmask [16] = '{32'h100, 32'h200, 32'h400, 32'h800, 32'h1000, 32'h2000,
                              32'h4000, 32'h8000, 32'h10000, 32'h20000, 32'h40, 32'h80,
                              32'h40000, 32'h80000, 32'hC0000, 32'h20040};
  logic [3:0] kcode [16] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001, 4'b1001,
                             4'b0111, 4'b1100, 4'b1000, 4'b1011, 4'b1010, 4'b0101,
                             4'b0100, 4'b0010, 4'b0100, 4'b1011};

  cv_ctrl_mux #(
    .NUM_PLAYERS (NP),
    .HOLD_CE     (HOLD),
    .STEP_CE     (STEP),
    .ACC_W       (ACC_W)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .ce_i        (ce),
    .joy_i       (joy),
    .spinner_i   (spin),
    .ctrl_p5_i   (p5),
    .ctrl_p8_i   (p8),
    .ctrl_p1_4_o (p14),
    .ctrl_p6_o   (p6),
    .ctrl_p7_o   (p7),
    .ctrl_p9_o   (p9)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("check %s: got %0h ok", tag, act);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

`ifdef CV_ROLLER_EN
  task automatic count_steps(input int n, output int steps);
    logic [1:0] prev;
    prev  = {p7[1], p9[1]};
    steps = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if ({p7[1], p9[1]} != prev) steps++;
      prev = {p7[1], p9[1]};
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    // Reset with every joystick bit set and both selects asserted
    joy = '1; p5 = '0; p8 = '0; reset_n = 1'b0;
    cyc(3);
    chk("rst_p1_4", p14, 8'hFF);
    chk("rst_p6", p6, 2'b11);
    chk("rst_p7", p7, 2'b11);
    chk("rst_p9", p9, 2'b11);

    reset_n = 1'b1; p5 = 2'b10; p8 = 2'b01;
    cyc(2);
    chk("prio_dig0", p14[3:0], 4'b0011);
    chk("p6_btn2", p6[0], 1'b0);
    chk("js_all", p14[7:4], 4'b0000);
    chk("p6_btn1", p6[1], 1'b0);
    joy = '0; p5 = '1; p8 = '1;
    cyc(H + 4);

    // Digit 1 pulsed for 10 ticks, stretched to the hold time
    p5[0] = 1'b0; joy[31:0] = 32'h200;
    cyc(1);
    chk("lat_old", p14[3:0], 4'b1111);
    cyc(1);
    chk("dig1", p14[3:0], 4'b1110);
    cyc(8);
    joy[31:0] = '0; p5[0] = 1'b1;
    cyc(1);
    chk("desel", p14[3:0], 4'b1111);
    p5[0] = 1'b0;
    cyc(1);
    chk("resel", p14[3:0], 4'b1110);
    cyc(H - 10);
    chk("hold_end", p14[3:0], 4'b1110);
    cyc(1);
    chk("hold_rel", p14[3:0], 4'b1111);

    // Joystick select, then both selects together
    p5[0] = 1'b1; p8[0] = 1'b0; joy[31:0] = 32'h18;
    cyc(1);
    chk("js_up", p14[3:0], 4'b0111);
    chk("js_fire", p6[0], 1'b0);
    p5[0] = 1'b0; joy[31:0] = 32'h418;
    cyc(2);
    chk("both_and", p14[3:0], 4'b0101);
    chk("both_fire", p6[0], 1'b0);
    joy[31:0] = 32'h408;
    cyc(1);
    chk("fire_rel", p6[0], 1'b1);
    joy = '0; p8[0] = 1'b1;
    cyc(H + 4);

    // Press during an active hold is ignored until expiry
    joy[31:0] = 32'h200;
    cyc(2);
    chk("mid_a", p14[3:0], 4'b1110);
    joy[31:0] = 32'h800;
    cyc(5);
    chk("mid_ign", p14[3:0], 4'b1110);
    cyc(H - 5);
    chk("mid_last", p14[3:0], 4'b1110);
    cyc(1);
    chk("mid_new", p14[3:0], 4'b0110);
    cyc(H + 3);
    joy[31:0] = 32'h1000;
    cyc(2);
    chk("no_reload", p14[3:0], 4'b0001);

    // Hold counter only advances on ce
    ce = 1'b0; joy = '0;
    cyc(3 * H);
    chk("ce_gate", p14[3:0], 4'b0001);
    ce = 1'b1;
    cyc(H + 2);
    chk("ce_run", p14[3:0], 4'b1111);

    // Reset in the middle of a hold
    joy[31:0] = 32'h200;
    cyc(3);
    reset_n = 1'b0;
    cyc(1);
    chk("rst_mid", p14[3:0], 4'b1111);
    reset_n = 1'b1; joy[31:0] = 32'h400;
    cyc(2);
    chk("post_rst", p14[3:0], 4'b1101);
    joy = '0;
    cyc(H + 4);

    // Player 1 keypad table, including priority cases
    p5 = 2'b01; p8 = 2'b11;
    for (int i = 0; i < 16; i++) begin
      joy[63:32] = kmask[i];
      cyc(2);
      chk($sformatf("key%0d", i), p14[7:4], kcode[i]);
      joy[63:32] = '0;
      cyc(H + 1);
      chk($sformatf("key%0d_rel", i), p14[7:4], 4'b1111);
    end
    chk("p0_idle", p14[3:0], 4'b1111);

`ifdef CV_ROLLER_EN
    // +3 then -2 on player 1
    do_reset();
    spin[17:9] = {1'b1, 8'd3};
    cyc(7);
    chk("q_r7", {p7[1], p9[1]}, 2'b11);
    cyc(1);
    chk("q_r8", {p7[1], p9[1]}, 2'b01);
    cyc(7);
    chk("q_r15", {p7[1], p9[1]}, 2'b01);
    cyc(1);
    chk("q_r16", {p7[1], p9[1]}, 2'b00);
    cyc(8);
    chk("q_r24", {p7[1], p9[1]}, 2'b10);
    cyc(16);
    chk("q_hold", {p7[1], p9[1]}, 2'b10);
    spin[17:9] = {1'b0, 8'hFE};
    cyc(8);
    chk("q_rev1", {p7[1], p9[1]}, 2'b00);
    cyc(8);
    chk("q_rev2", {p7[1], p9[1]}, 2'b01);
    cyc(8);
    chk("q_rev_hold", {p7[1], p9[1]}, 2'b01);
    chk("q_p0_idle", {p7[0], p9[0]}, 2'b11);

    // Five +127 events saturate at 511
    do_reset();
    for (int k = 0; k < 5; k++) begin
      spin[17] = ~spin[17]; spin[16:9] = 8'd127;
      cyc(1);
    end
    count_steps(4395, steps);
    chk("sat_steps", steps, 511);
    chk("sat_phase", {p7[1], p9[1]}, 2'b10);

    // Event landing on a step wrap: 2 + 5 - 1 = 6 left after the first step
    do_reset();
    spin[17] = ~spin[17]; spin[16:9] = 8'd2;
    cyc(7);
    spin[17] = ~spin[17]; spin[16:9] = 8'd5;
    count_steps(100, steps);
    chk("coinc_steps", steps, 7);
    chk("coinc_phase", {p7[1], p9[1]}, 2'b10);
`else
    spin = {1'b1, 8'd5, 1'b1, 8'd5};
    cyc(20);
    spin = {1'b0, 8'd5, 1'b0, 8'd5};
    cyc(20);
    chk("no_roller_p7", p7, 2'b11);
    chk("no_roller_p9", p9, 2'b11);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
